// File: rtl/d_mem_responder_pkg.sv
// d_mem_responder_pkg: shared datapath defines (FSM state codes, ALU command codes, bus width)
package d_mem_responder_pkg;

    localparam int DATA_W = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_cmd_t;

endpackage

// File: rtl/d_mem_responder_dmem_array.sv
// dmem_array: 2**addr_bits x 64 storage, one synchronous write port, one asynchronous read port
//   clk            rising-edge clock
//   we/waddr/wdata write port, applied at the edge
//   raddr/rdata    combinational read port
module dmem_array
    import d_mem_responder_pkg::*;
#(
    parameter int addr_bits = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [addr_bits-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [addr_bits-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**addr_bits];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/d_mem_responder.sv
// d_mem_responder: data-memory responder with post-reset clear sweep, preload port and saturating access counters
//   clk, rst_n           clock, asynchronous active-low reset
//   d_mem_addr/we        datapath word address and write strobe
//   d_mem_data           shared bus: datapath drives on writes, this block drives reads once ready
//   mem_ready            high once every word has been cleared
//   ld_valid/ld_ready    preload handshake; ld_addr/ld_wdata are the preload word and data
//   rd_count/wr_count    saturating counts of datapath read and write cycles
module d_mem_responder
    import d_mem_responder_pkg::*;
#(
    parameter int d_addr_bits = 6,
    parameter int cnt_bits    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [d_addr_bits-1:0] d_mem_addr,
    inout  wire  [DATA_W-1:0]      d_mem_data,
    input  logic                   d_mem_we,
    output logic                   mem_ready,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [d_addr_bits-1:0] ld_addr,
    input  logic [DATA_W-1:0]      ld_wdata,
    output logic [cnt_bits-1:0]    rd_count,
    output logic [cnt_bits-1:0]    wr_count
);

    state_t                 state, state_nxt;
    logic [d_addr_bits-1:0] ptr;
    logic                   we;
    logic [d_addr_bits-1:0] waddr;
    logic [DATA_W-1:0]      wdata, rdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) ptr <= ptr + d_addr_bits'(1);
        end

    // Single write port, priority sweep > datapath write > preload.
    always_comb begin
        state_nxt = state;
        mem_ready = state == ST_RUN;
        ld_ready  = mem_ready & ~d_mem_we;
        we        = 1'b0;
        waddr     = d_mem_addr;
        wdata     = d_mem_data;
        if (!mem_ready) begin
            we    = 1'b1;
            waddr = ptr;
            wdata = '0;
            if (ptr == '1) state_nxt = ST_RUN;
        end else if (d_mem_we) begin
            we = 1'b1;
        end else if (ld_valid) begin
            we    = 1'b1;
            waddr = ld_addr;
            wdata = ld_wdata;
        end
    end

    dmem_array #(.addr_bits(d_addr_bits)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (d_mem_addr),
        .rdata (rdata)
    );

    // Never drive while the datapath writes or before the sweep is done.
    assign d_mem_data = (mem_ready && !d_mem_we) ? rdata : 'z;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (mem_ready) begin
            if (d_mem_we) begin
                if (wr_count != '1) wr_count <= wr_count + cnt_bits'(1);
            end else if (rd_count != '1) begin
                rd_count <= rd_count + cnt_bits'(1);
            end
        end

endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder: randomized self-checking bench against a cycle-level memory/counter model
module tb_d_mem_responder;

    logic        clk, rst_n, we, ld_valid;
    logic [5:0]  addr, ld_addr;
    logic [63:0] tb_bus, ld_wdata;
    wire  [63:0] d_mem_data;
    logic        mem_ready, ld_ready;
    logic [15:0] rd_count, wr_count;

    wire  [63:0] s_bus;
    logic        s_we, s_ldv, s_ready, s_ld_ready;
    logic [3:0]  s_rd, s_wr;

    int nvec, nerr, cyc, m_rd, m_wr, m_srd;
    logic [63:0] mmem [64];

    assign d_mem_data = we ? tb_bus : 'z;

    d_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .d_mem_addr(addr), .d_mem_data(d_mem_data), .d_mem_we(we),
        .mem_ready(mem_ready), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .rd_count(rd_count), .wr_count(wr_count)
    );

    d_mem_responder #(.d_addr_bits(6), .cnt_bits(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .d_mem_addr(addr), .d_mem_data(s_bus), .d_mem_we(s_we),
        .mem_ready(s_ready), .ld_valid(s_ldv), .ld_ready(s_ld_ready), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .rd_count(s_rd), .wr_count(s_wr)
    );

    always #5 clk = ~clk;

    // Model: word cyc is zeroed on clock cyc of the sweep; from clock 64 on the memory is live.
    task automatic tick();
        if (cyc >= 64) begin
            if (we) begin
                mmem[addr] = tb_bus;
                if (m_wr < 65535) m_wr++;
            end else begin
                if (m_rd < 65535) m_rd++;
                if (ld_valid) mmem[ld_addr] = ld_wdata;
            end
            if (m_srd < 15) m_srd++;
        end else begin
            mmem[cyc] = 64'h0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        we = 0;
        ld_valid = 0;
        cyc = 0;
        m_rd = 0;
        m_wr = 0;
        m_srd = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 0;
        #2;
        nvec++;
        if (mem_ready !== 1'b0 || ld_ready !== 1'b0 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
            nerr++;
            $display("FAIL reset_outputs: ready=%b ld_ready=%b rd=%0d wr=%0d, want 0 0 0 0", mem_ready, ld_ready, rd_count, wr_count);
        end
        do_reset();
        n = 0;
        while (!mem_ready && n < 200) begin
            we = 1'($urandom_range(0, 1));
            addr = 6'($urandom);
            tb_bus = {$urandom, $urandom};
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr = 6'($urandom);
            ld_wdata = {$urandom, $urandom};
            #1;
            nvec++;
            if (ld_ready !== 1'b0) begin
                nerr++;
                $display("FAIL sweep_ld_ready: got %b want 0", ld_ready);
            end
            if (!we) begin
                nvec++;
                if (d_mem_data !== 64'h0 && d_mem_data !== {64{1'bz}}) begin
                    nerr++;
                    $display("FAIL sweep_bus_driven: got %h want undriven", d_mem_data);
                end
            end
            tick();
            n++;
            nvec++;
            if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
                nerr++;
                $display("FAIL sweep_counters: rd=%0d wr=%0d want 0 0", rd_count, wr_count);
            end
        end
        nvec++;
        if (n != 64) begin
            nerr++;
            $display("FAIL ready_latency: got %0d cycles want 64", n);
        end
        we = 0;
        ld_valid = 0;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            #1;
            nvec++;
            if (d_mem_data !== 64'h0) begin
                nerr++;
                $display("FAIL clear_read[%0d]: got %h want 0", a, d_mem_data);
            end
            tick();
        end
    endtask

    task automatic test_preload();
        we = 0;
        addr = 0;
        ld_valid = 1;
        ld_addr = 5;
        ld_wdata = 64'hDEAD_BEEF_0123_4567;
        #1;
        nvec++;
        if (ld_ready !== 1'b1) begin
            nerr++;
            $display("FAIL preload_ready: got %b want 1", ld_ready);
        end
        tick();
        ld_valid = 0;
        addr = 5;
        #1;
        nvec++;
        if (d_mem_data !== 64'hDEAD_BEEF_0123_4567) begin
            nerr++;
            $display("FAIL preload_read: got %h want deadbeef01234567", d_mem_data);
        end
        tick();
        nvec++;
        if (rd_count !== 16'(m_rd) || m_rd != 66) begin
            nerr++;
            $display("FAIL preload_rd_count: got %0d want %0d", rd_count, m_rd);
        end
    endtask

    task automatic test_cpu_write();
        we = 1;
        addr = 9;
        tb_bus = 64'hA5A5;
        #1;
        nvec++;
        if (d_mem_data !== 64'hA5A5 || ld_ready !== 1'b0) begin
            nerr++;
            $display("FAIL write_bus: bus=%h ld_ready=%b want a5a5 0", d_mem_data, ld_ready);
        end
        tick();
        we = 0;
        #1;
        nvec++;
        if (d_mem_data !== 64'hA5A5) begin
            nerr++;
            $display("FAIL raw_read: got %h want a5a5", d_mem_data);
        end
        nvec++;
        if (wr_count !== 16'd1) begin
            nerr++;
            $display("FAIL wr_count_one: got %0d want 1", wr_count);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [63:0] oldv;
        oldv = mmem[12];
        ld_valid = 1;
        ld_addr = 12;
        ld_wdata = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 3; i++) begin
            we = 1;
            addr = 30;
            tb_bus = {$urandom, $urandom};
            #1;
            nvec++;
            if (ld_ready !== 1'b0) begin
                nerr++;
                $display("FAIL stall_ld_ready[%0d]: got %b want 0", i, ld_ready);
            end
            tick();
        end
        we = 0;
        addr = 12;
        #1;
        nvec++;
        if (ld_ready !== 1'b1 || d_mem_data !== oldv) begin
            nerr++;
            $display("FAIL stall_unchanged: ld_ready=%b bus=%h want 1 %h", ld_ready, d_mem_data, oldv);
        end
        tick();
        ld_valid = 0;
        #1;
        nvec++;
        if (d_mem_data !== 64'h1122_3344_5566_7788) begin
            nerr++;
            $display("FAIL stall_accept: got %h want 1122334455667788", d_mem_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        we = 0;
        ld_valid = 1;
        ld_addr = 60;
        ld_wdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        ld_valid = 0;
        do_reset();
        addr = 60;
        for (int i = 0; i < 20; i++) tick();
        do_reset();
        n = 0;
        while (!mem_ready && n < 200) begin
            #1;
            nvec++;
            if (d_mem_data !== 64'h0 && d_mem_data !== {64{1'bz}}) begin
                nerr++;
                $display("FAIL midrst_bus_driven: got %h want undriven", d_mem_data);
            end
            tick();
            n++;
        end
        nvec++;
        if (n != 64) begin
            nerr++;
            $display("FAIL midrst_latency: got %0d cycles want 64", n);
        end
        #1;
        nvec++;
        if (d_mem_data !== 64'h0) begin
            nerr++;
            $display("FAIL midrst_cleared60: got %h want 0", d_mem_data);
        end
        tick();
        addr = 5;
        #1;
        nvec++;
        if (d_mem_data !== 64'h0) begin
            nerr++;
            $display("FAIL midrst_cleared5: got %h want 0", d_mem_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 2) == 0);
            addr = 6'($urandom_range(0, 15));
            tb_bus = {$urandom, $urandom};
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr = 6'($urandom_range(0, 15));
            ld_wdata = {$urandom, $urandom};
            #1;
            nvec++;
            if (ld_ready !== !we) begin
                nerr++;
                $display("FAIL rand_ld_ready[%0d]: got %b want %b", i, ld_ready, !we);
            end
            nvec++;
            if (d_mem_data !== (we ? tb_bus : mmem[addr])) begin
                nerr++;
                $display("FAIL rand_bus[%0d]: got %h want %h", i, d_mem_data, we ? tb_bus : mmem[addr]);
            end
            tick();
            nvec++;
            if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr)) begin
                nerr++;
                $display("FAIL rand_counters[%0d]: rd=%0d wr=%0d want %0d %0d", i, rd_count, wr_count, m_rd, m_wr);
            end
        end
        we = 0;
        ld_valid = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        addr = 0;
        for (int i = 0; i < 64; i++) tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            nvec++;
            if (s_rd !== 4'(m_srd) || s_rd !== 4'(i > 15 ? 15 : i) || s_wr !== 4'd0) begin
                nerr++;
                $display("FAIL sat_rd[%0d]: rd=%0d wr=%0d want %0d 0", i, s_rd, s_wr, i > 15 ? 15 : i);
            end
        end
        nvec++;
        if (s_rd !== 4'hF) begin
            nerr++;
            $display("FAIL sat_final: got %h want f", s_rd);
        end
    endtask

    initial begin
        clk = 0;
        rst_n = 0;
        we = 0;
        addr = 0;
        tb_bus = 0;
        ld_valid = 0;
        ld_addr = 0;
        ld_wdata = 0;
        s_we = 0;
        s_ldv = 0;
        nvec = 0;
        nerr = 0;
        cyc = 0;
        m_rd = 0;
        m_wr = 0;
        m_srd = 0;
        for (int i = 0; i < 64; i++) mmem[i] = 64'h0;
        test_reset();
        test_preload();
        test_cpu_write();
        test_stall();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
